conv_mem_reader: RTL and testbench
==================================

Name: conv_mem_reader

Overview:
Responder side of the control-block load handshake. It sees read_enable and img_weight_sel from the controller and fetches a weight or image block from a synchronous SRAM. It streams the words to the datapath over a valid/ready interface. When the last word has been accepted, it pulses finish_read back to the controller.

Parameters:
DATA_W, 8, width of memory word and output data
ADDR_W, 12, memory address width
WEIGHT_BASE, 0, first address of the weight block
WEIGHT_LEN, 9, number of weight words (>=1)
IMG_BASE, 16, first address of the image block
IMG_LEN, 64, number of image words (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
read_enable  in  1  level request from the controller; held high for the whole job
img_weight_sel  in  1  1 = weights, 0 = image; sampled only at job start
mem_rd  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM read address
mem_rdata  in  DATA_W  SRAM read data; valid exactly 1 cycle after mem_rd
out_valid  out  1  output word available
out_data  out  DATA_W  output word
out_sel  out  1  latched img_weight_sel tag for out_data
out_ready  in  1  consumer accepts the word when out_valid && out_ready
finish_read  out  1  single-cycle pulse: all words of the job accepted

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_rd = 0, mem_addr = 0.
  - out_valid = 0, out_data = 0, out_sel = 0.
  - finish_read = 0.
  - Buffer empty, in-flight flag 0, counters 0.
- States: IDLE, FETCH, DRAIN, DONE, RELEASE.
- IDLE:
  - If read_enable = 1 at a clock edge, go to FETCH.
  - Latch sel = img_weight_sel.
  - Load addr = sel ? WEIGHT_BASE : IMG_BASE.
  - Load issue_cnt and accept_cnt = sel ? WEIGHT_LEN : IMG_LEN.
- FETCH:
  - mem_rd and mem_addr are combinational from state and counters.
  - Issue a read when issue_cnt > 0 and (buf_count + in_flight < 2, or a pop happens this cycle).
  - Each issue: addr +1, issue_cnt -1, in_flight set for the next cycle.
  - Go to DRAIN when the last read is issued.
- Buffer:
  - 2-entry FIFO; out_data is the FIFO head, out_valid = buf_count != 0.
  - mem_rdata is written when in_flight = 1.
  - A simultaneous push and pop keeps the count.
  - The FIFO can never overflow because of the issue rule.
  - With out_ready held at 1, throughput is 1 word/cycle.
  - Read latency from mem_rd to out_valid is 2 cycles.
- Accept counting:
  - Each accept decrements accept_cnt.
  - When the final accept occurs (accept_cnt == 1 and pop), go to DONE.
- DONE: finish_read = 1 for exactly one cycle, then go to RELEASE.
- RELEASE:
  - Wait for read_enable = 0, then go to IDLE.
  - This prevents a restart caused by the controller's registered read_enable lag.
- Abort:
  - If read_enable = 0 in FETCH or DRAIN: go to IDLE next cycle.
  - Flush the FIFO and discard any in-flight return; finish_read is not asserted.
- Ignored inputs:
  - img_weight_sel changes mid-job are ignored.
  - out_ready while out_valid = 0 is ignored.
- out_sel equals the latched sel for the whole job.
- Address arithmetic: ADDR_W bits, wraps modulo 2^ADDR_W with no error.
- Asynchronous reset mid-job immediately forces all reset values.

Optional Feature:
Macro: CONV_MEM_READER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (16 bits): the modular sum of all accepted out_data words of the current job, zero-extended.
  - Cleared on the job-start edge.
  - Held stable from the DONE cycle until the next job start.
- Undefined: the port and the accumulator do not exist.
- All other behaviour is identical in both builds.

Test Plan:
- Weight load, out_ready = 1, WEIGHT_LEN = 9:
  - read_enable rises in cycle 0 (IDLE), sel = 1.
  - mem_rd is high in cycles 1-9 with addr 0..8.
  - out_valid is high in cycles 3-11, data matching memory.
  - finish_read pulses in cycle 12 only; out_sel = 1 throughout.
- Image load with backpressure:
  - sel = 0, out_ready toggles 1,0,0,1 repeating.
  - 64 words from addresses 16..79 arrive in order with no duplicates or drops.
  - mem_rd never issues when buf_count + in_flight = 2 without a pop.
  - Exactly one finish_read.
- Release:
  - read_enable held high 2 cycles after finish_read → stays in RELEASE, no new mem_rd.
  - read_enable low for 1 cycle then high with sel = 0 → a new image job starts at addr 16.
- Abort:
  - read_enable drops after 4 words are accepted → out_valid = 0 within 1 cycle.
  - No finish_read.
  - A following weight job restarts at addr 0 with a full count of 9.
- Async reset:
  - rst asserted mid-FETCH (not clock-aligned) → all outputs at reset values immediately.
  - After release, the next job starts cleanly.
- CONV_MEM_READER_CHECKSUM_EN, weight memory = 1..9:
  - checksum = 45 (0x002D) at the finish_read cycle.
  - Next job shows the checksum cleared at its start.

Source files
------------

// File: rtl/conv_mem_reader.sv
// conv_mem_reader
//   Responder side of the control-block load handshake. When the controller
//   raises read_enable, the block fetches either the weight block or the image
//   block from a synchronous SRAM (1-cycle read latency). It streams the words
//   out over a valid/ready interface through a 2-entry skid FIFO. When the
//   final word has been accepted, it pulses finish_read for one cycle.
//
// Ports
//   clk            clock
//   rst            reset, asynchronous, active-low
//   read_enable    level request from the controller, held for the whole job
//   img_weight_sel 1 = weights, 0 = image; sampled only at job start
//   mem_rd         SRAM read strobe
//   mem_addr       SRAM read address
//   mem_rdata      SRAM read data, valid one cycle after mem_rd
//   out_valid      output word available (FIFO not empty)
//   out_data       output word (FIFO head)
//   out_sel        job tag (latched img_weight_sel)
//   out_ready      consumer accepts when out_valid && out_ready
//   finish_read    one-cycle pulse once every word of the job is accepted
//   checksum       (only with CONV_MEM_READER_CHECKSUM_EN) 16-bit modular sum
//                  of the accepted words of the current job
//
// Optional build macro: CONV_MEM_READER_CHECKSUM_EN adds the checksum port and
// its accumulator. When the macro is undefined, neither exists.
module conv_mem_reader #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 12,
    parameter int WEIGHT_BASE = 0,
    parameter int WEIGHT_LEN  = 9,
    parameter int IMG_BASE    = 16,
    parameter int IMG_LEN     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_enable,
    input  logic              img_weight_sel,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    input  logic              out_ready,
    output logic              finish_read
`ifdef CONV_MEM_READER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int MAX_LEN = (WEIGHT_LEN > IMG_LEN) ? WEIGHT_LEN : IMG_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE,
        RELEASE
    } state_t;

    state_t             state_reg, state_next;
    logic               sel_reg, sel_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [CNT_W-1:0]   issue_cnt_reg, issue_cnt_next;
    logic [CNT_W-1:0]   accept_cnt_reg, accept_cnt_next;
    logic               in_flight_reg, in_flight_next;

    // FIFO bookkeeping
    logic               wr_ptr_reg, wr_ptr_next;
    logic               rd_ptr_reg, rd_ptr_next;
    logic [1:0]         buf_count_reg, buf_count_next;

    logic               active;
    logic               abort;
    logic               pop;
    logic               push;
    logic               issue;
    logic [1:0]         occupancy;

    // ------------------------------------------------------------------
    // Handshake-level signals
    // ------------------------------------------------------------------
    assign active    = (state_reg == FETCH) || (state_reg == DRAIN);
    assign abort     = active && !read_enable;
    assign out_valid = (buf_count_reg != 2'd0);
    assign pop       = active && out_valid && out_ready;
    // A return is only kept while the job is still alive; on abort it is dropped.
    assign push      = in_flight_reg && !abort;

    // Words already buffered plus the one coming back from SRAM. A new read is
    // only allowed when it is guaranteed a FIFO slot on return, either because
    // there is room now or because a word leaves this cycle.
    assign occupancy = buf_count_reg + {1'b0, in_flight_reg};
    assign issue     = (state_reg == FETCH) && read_enable &&
                       (issue_cnt_reg != '0) &&
                       ((occupancy < 2'd2) || pop);

    assign mem_rd      = issue;
    assign mem_addr    = (state_reg == FETCH) ? addr_reg : '0;
    assign out_sel     = sel_reg;
    assign finish_read = (state_reg == DONE);

    // ------------------------------------------------------------------
    // Control FSM: next-state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        addr_next       = addr_reg;
        issue_cnt_next  = issue_cnt_reg;
        accept_cnt_next = accept_cnt_reg;
        in_flight_next  = issue;

        case (state_reg)
            IDLE: begin
                if (read_enable) begin
                    state_next      = FETCH;
                    sel_next        = img_weight_sel;
                    addr_next       = img_weight_sel ? ADDR_W'(WEIGHT_BASE)
                                                     : ADDR_W'(IMG_BASE);
                    issue_cnt_next  = img_weight_sel ? CNT_W'(WEIGHT_LEN)
                                                     : CNT_W'(IMG_LEN);
                    accept_cnt_next = img_weight_sel ? CNT_W'(WEIGHT_LEN)
                                                     : CNT_W'(IMG_LEN);
                end
            end

            FETCH, DRAIN: begin
                if (!read_enable) begin
                    // Controller withdrew the request: drop everything.
                    state_next      = IDLE;
                    issue_cnt_next  = '0;
                    accept_cnt_next = '0;
                end else begin
                    if (issue) begin
                        addr_next      = addr_reg + ADDR_W'(1);
                        issue_cnt_next = issue_cnt_reg - CNT_W'(1);
                    end
                    if (pop) begin
                        accept_cnt_next = accept_cnt_reg - CNT_W'(1);
                    end
                    if (pop && (accept_cnt_reg == CNT_W'(1))) begin
                        state_next = DONE;
                    end else if ((state_reg == FETCH) && issue &&
                                 (issue_cnt_reg == CNT_W'(1))) begin
                        state_next = DRAIN;
                    end
                end
            end

            DONE: begin
                state_next = RELEASE;
            end

            RELEASE: begin
                // The controller's read_enable lags by a cycle; wait for it to
                // drop so the same request is not mistaken for a new job.
                if (!read_enable) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            sel_reg        <= 1'b0;
            addr_reg       <= '0;
            issue_cnt_reg  <= '0;
            accept_cnt_reg <= '0;
            in_flight_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            addr_reg       <= addr_next;
            issue_cnt_reg  <= issue_cnt_next;
            accept_cnt_reg <= accept_cnt_next;
            in_flight_reg  <= in_flight_next;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        buf_count_next = buf_count_reg;

        if (abort) begin
            wr_ptr_next    = 1'b0;
            rd_ptr_next    = 1'b0;
            buf_count_next = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            if (push && !pop) begin
                buf_count_next = buf_count_reg + 2'd1;
            end else if (pop && !push) begin
                buf_count_next = buf_count_reg - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            buf_count_reg <= 2'd0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            buf_count_reg <= buf_count_next;
        end
    end

    // One register per FIFO slot, written when the returning word lands on it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign out_data = rd_ptr_reg ? g_buf[1].entry_reg : g_buf[0].entry_reg;

`ifdef CONV_MEM_READER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Checksum of accepted words. It is cleared on the job-start edge and only
    // moves on accepts, so it is naturally stable from DONE to the next start.
    // ------------------------------------------------------------------
    logic [15:0] sum_reg, sum_next;

    always_comb begin
        sum_next = sum_reg;
        if ((state_reg == IDLE) && read_enable) begin
            sum_next = '0;
        end else if (pop) begin
            sum_next = sum_reg + 16'(out_data);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= sum_next;
        end
    end

    assign checksum = sum_reg;
`endif

endmodule

// File: tb/tb_conv_mem_reader.sv
// Testbench for conv_mem_reader: directed jobs (weight load, image load with
// backpressure, release handling, abort, asynchronous reset) against a
// behavioural SRAM whose word at address a holds (a + 1) mod 256.
module tb_conv_mem_reader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              read_enable;
    logic              img_weight_sel;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sel;
    logic              out_ready;
    logic              finish_read;
`ifdef CONV_MEM_READER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    logic [DATA_W-1:0] mem_array [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    conv_mem_reader #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .WEIGHT_BASE (0),
        .WEIGHT_LEN  (9),
        .IMG_BASE    (16),
        .IMG_LEN     (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .read_enable    (read_enable),
        .img_weight_sel (img_weight_sel),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_sel        (out_sel),
        .out_ready      (out_ready),
        .finish_read    (finish_read)
`ifdef CONV_MEM_READER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    // Synchronous SRAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem_array[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full weight job with out_ready held at 1. Cycle 0 is the IDLE cycle in
    // which read_enable rises; expected timing is fixed by hand:
    // mem_rd cycles 1..9 (addr c-1), out_valid cycles 3..11 (data c-2),
    // finish_read cycle 12 only.
    task automatic run_weight_job();
        int words = 0;
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            read_enable    = 1'b1;
            img_weight_sel = (c == 0) ? 1'b1 : c[0];
            out_ready      = 1'b1;
            #2;
            check("w_mem_rd", 32'(mem_rd), 32'((c >= 1) && (c <= 9)));
            if ((c >= 1) && (c <= 9)) begin
                check("w_mem_addr", 32'(mem_addr), c - 1);
            end
            check("w_out_valid", 32'(out_valid), 32'((c >= 3) && (c <= 11)));
            if ((c >= 3) && (c <= 11)) begin
                check("w_out_data", 32'(out_data), c - 2);
                words++;
            end
            check("w_finish", 32'(finish_read), 32'(c == 12));
            if ((c >= 1) && (c <= 12)) begin
                check("w_out_sel", 32'(out_sel), 1);
            end
`ifdef CONV_MEM_READER_CHECKSUM_EN
            if ((c == 1) || (c == 2)) begin
                check("w_cksum_clear", 32'(checksum), 0);
            end
            if ((c == 12) || (c == 13)) begin
                check("w_cksum", 32'(checksum), 45);
            end
`endif
        end
        $display("weight job: %0d words streamed", words);
    endtask

    // Image job with out_ready pattern 1,0,0,1. Ends in the finish_read cycle.
    task automatic run_image_job();
        int   issued   = 0;
        int   accepted = 0;
        int   cyc      = 0;
        bit   done     = 1'b0;
        logic pop_now;
        while (!done && (cyc < 600)) begin
            next_cycle();
            read_enable    = 1'b1;
            img_weight_sel = (cyc == 0) ? 1'b0 : cyc[1];
            out_ready      = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #2;
            pop_now = out_valid && out_ready;
            if (mem_rd) begin
                check("img_addr", 32'(mem_addr), 16 + issued);
                check("img_issue_rule", 32'(((issued - accepted) < 2) || pop_now), 1);
                issued++;
            end
            if (pop_now) begin
                check("img_data", 32'(out_data), 17 + accepted);
                check("img_sel", 32'(out_sel), 0);
                accepted++;
            end
            if (finish_read) begin
                done = 1'b1;
            end
            cyc++;
        end
        check("img_finish_seen", 32'(done), 1);
        check("img_words_accepted", accepted, 64);
        check("img_reads_issued", issued, 64);
        $display("image job: %0d reads issued, %0d words accepted, %0d cycles", issued, accepted, cyc);
    endtask

    initial begin
        int accepted;

        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem_array[i] = 8'(i + 1);
        end
        mem_rdata      = '0;
        read_enable    = 1'b0;
        img_weight_sel = 1'b0;
        out_ready      = 1'b0;

        // Power-on reset
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_sel", 32'(out_sel), 0);
        check("rst_finish", 32'(finish_read), 0);
        #24 rst = 1'b1;

        // Weight load
        run_weight_job();
        next_cycle();
        read_enable = 1'b0;

        // Image load under backpressure
        run_image_job();

        // Release: read_enable stays high two cycles after finish_read
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            read_enable = 1'b1;
            out_ready   = 1'b1;
            #2;
            check("rel_mem_rd", 32'(mem_rd), 0);
            check("rel_out_valid", 32'(out_valid), 0);
            check("rel_finish", 32'(finish_read), 0);
        end
        next_cycle();
        read_enable = 1'b0;
        #2;
        check("rel_low_mem_rd", 32'(mem_rd), 0);
        next_cycle();
        read_enable    = 1'b1;
        img_weight_sel = 1'b0;
        #2;
        check("rel_idle_mem_rd", 32'(mem_rd), 0);
        $display("release: held in RELEASE, new image job requested");

        // New image job, aborted after 4 accepted words
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            #2;
            if (c == 0) begin
                check("abort_first_rd", 32'(mem_rd), 1);
                check("abort_first_addr", 32'(mem_addr), 16);
            end
            if (out_valid && out_ready) begin
                check("abort_data", 32'(out_data), 17 + accepted);
                accepted++;
            end
            check("abort_no_finish", 32'(finish_read), 0);
        end
        check("abort_accepted", accepted, 4);
        next_cycle();
        out_ready   = 1'b0;
        read_enable = 1'b0;
        #2;
        check("abort_cycle_finish", 32'(finish_read), 0);
        next_cycle();
        #2;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_mem_rd", 32'(mem_rd), 0);
        check("abort_finish", 32'(finish_read), 0);
        next_cycle();
        #2;
        check("abort_idle_valid", 32'(out_valid), 0);
        check("abort_idle_finish", 32'(finish_read), 0);
        $display("abort: job dropped after %0d words", accepted);

        // Weight job after abort must restart at address 0 with 9 words
        run_weight_job();
        next_cycle();
        read_enable = 1'b0;

        // Asynchronous reset in the middle of a weight fetch
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            read_enable    = 1'b1;
            img_weight_sel = 1'b1;
            out_ready      = 1'b1;
        end
        #3 rst = 1'b0;
        #1;
        check("arst_mem_rd", 32'(mem_rd), 0);
        check("arst_mem_addr", 32'(mem_addr), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_data", 32'(out_data), 0);
        check("arst_out_sel", 32'(out_sel), 0);
        check("arst_finish", 32'(finish_read), 0);
`ifdef CONV_MEM_READER_CHECKSUM_EN
        check("arst_cksum", 32'(checksum), 0);
`endif
        read_enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        $display("async reset: asserted mid-fetch and released");

        // Clean job after reset
        run_weight_job();
        next_cycle();
        read_enable = 1'b0;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
